apb_timer_slave: RTL and testbench

APB3 completer holding a small register bank and a 32-bit down-counting timer with interrupt. It sits on the APB side of the AHB-to-APB bridge and answers the bridge's SETUP/ACCESS transfers. It inserts a programmable number of wait states via PREADY and flags illegal accesses with PSLVERR.

---
 rtl/apb_timer_pkg.sv | 24 ++
 rtl/apb_timer_core.sv | 42 ++++
 rtl/apb_timer_slave.sv | 156 +++++++++++++++
 tb/tb_apb_timer_slave.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer slave: register offsets, CTRL/STATUS
// bit positions and the transfer FSM state encoding.
package apb_timer_pkg;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_LOAD    = 5'h04;
  localparam logic [4:0] OFF_COUNT   = 5'h08;
  localparam logic [4:0] OFF_STATUS  = 5'h0C;
  localparam logic [4:0] OFF_SCRATCH0 = 5'h10;
  localparam logic [4:0] OFF_SCRATCH1 = 5'h14;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_RELOAD = 2;

  localparam int STATUS_EXPIRED = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timer_core.sv
// Down-counting timer: LOAD register, COUNT register and the sticky EXPIRED flag.
module apb_timer_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              reload,
  input  logic              load_stb,
  input  logic [DATA_W-1:0] load_val,
  input  logic              w1c_stb,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] load_value,
  output logic              expired
);

  logic tick;
  logic expire;

  // A LOAD write overrides both the decrement and the expiry of that cycle.
  assign tick   = en && (count != '0);
  assign expire = tick && (count == DATA_W'(1)) && !load_stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      load_value <= '0;
      expired    <= 1'b0;
    end else begin
      if (load_stb) begin
        load_value <= load_val;
        count      <= load_val;
      end else if (tick) begin
        if (count == DATA_W'(1)) count <= reload ? load_value : '0;
        else                     count <= count - DATA_W'(1);
      end
      if (expire)       expired <= 1'b1;
      else if (w1c_stb) expired <= 1'b0;
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// APB3 completer with programmable wait states, a small register bank and a
// down-counting timer raising a level interrupt.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 IRQ
);

  apb_state_e           state;
  logic [3:0]           wait_cnt;
  logic [2:0]           idx_q;
  logic                 wr_q;
  logic                 err_q;
  logic [2:0]           ctrl_q;
  logic [DATAWIDTH-1:0] scratch0;
  logic [DATAWIDTH-1:0] scratch1;
  logic [DATAWIDTH-1:0] count;
  logic [DATAWIDTH-1:0] load_value;
  logic                 expired;

  logic [2:0] idx_d;
  logic       err_d;
  logic       complete;
  logic       wr_ok;
  logic       ctrl_wr;
  logic       load_wr;
  logic       status_w1c;
  logic       en_eff;
  logic       addr_unused;

  assign idx_d = PADDR[4:2];
  assign err_d = ((PADDR >> 5) != '0) || (idx_d >= 3'd6) ||
                 (PWRITE && (idx_d == OFF_COUNT[4:2]));
  assign addr_unused = ^PADDR[1:0];

  assign complete   = (state == ST_READY) && PSEL && PENABLE;
  assign wr_ok      = complete && wr_q && !err_q;
  assign ctrl_wr    = wr_ok && (idx_q == OFF_CTRL[4:2]);
  assign load_wr    = wr_ok && (idx_q == OFF_LOAD[4:2]);
  assign status_w1c = wr_ok && (idx_q == OFF_STATUS[4:2]) && PWDATA[STATUS_EXPIRED];

  // Clearing EN on the completing edge must suppress that cycle's decrement/expiry.
  assign en_eff = ctrl_q[CTRL_EN] && !(ctrl_wr && !PWDATA[CTRL_EN]);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            idx_q    <= idx_d;
            wr_q     <= PWRITE;
            err_q    <= err_d;
            wait_cnt <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state   <= ST_READY;
              PREADY  <= 1'b1;
              PSLVERR <= err_d;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
          end else if (PENABLE) begin
            if (wait_cnt == 4'd1) begin
              state   <= ST_READY;
              PREADY  <= 1'b1;
              PSLVERR <= err_q;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
        end
        ST_READY: begin
          if (!PSEL || PENABLE) begin
            state   <= ST_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q   <= '0;
      scratch0 <= '0;
      scratch1 <= '0;
    end else if (wr_ok) begin
      if (idx_q == OFF_CTRL[4:2])     ctrl_q   <= PWDATA[2:0];
      if (idx_q == OFF_SCRATCH0[4:2]) scratch0 <= PWDATA;
      if (idx_q == OFF_SCRATCH1[4:2]) scratch1 <= PWDATA;
    end
  end

  apb_timer_core #(.DATA_W(DATAWIDTH)) u_core (
    .clk        (PCLK),
    .rst        (PRESET),
    .en         (en_eff),
    .reload     (ctrl_q[CTRL_RELOAD]),
    .load_stb   (load_wr),
    .load_val   (PWDATA),
    .w1c_stb    (status_w1c),
    .count      (count),
    .load_value (load_value),
    .expired    (expired)
  );

  always_comb begin
    PRDATA = '0;
    if ((state == ST_READY) && !err_q) begin
      case (idx_q)
        OFF_CTRL[4:2]:     PRDATA = {{(DATAWIDTH-3){1'b0}}, ctrl_q};
        OFF_LOAD[4:2]:     PRDATA = load_value;
        OFF_COUNT[4:2]:    PRDATA = count;
        OFF_STATUS[4:2]:   PRDATA = {{(DATAWIDTH-1){1'b0}}, expired};
        OFF_SCRATCH0[4:2]: PRDATA = scratch0;
        OFF_SCRATCH1[4:2]: PRDATA = scratch1;
        default:           PRDATA = '0;
      endcase
    end
  end

  assign IRQ = expired && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Scoreboarded bench for apb_timer_slave with a cycle-level reference model.
module tb_apb_timer_slave;

  localparam int WAIT = 2;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic [15:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        IRQ;

  always #5 PCLK = ~PCLK;

  apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_CYCLES(WAIT)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .IRQ     (IRQ)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the register bank and timer
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count, m_s0, m_s1;
  logic        m_exp;

  // Transfer completing at the next edge, as seen by the model
  logic        c_commit, c_wr, c_err;
  logic [2:0]  c_idx;
  logic [31:0] c_wdata;

  typedef struct { logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];

  logic [31:0] rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return {29'b0, m_ctrl};
      3'd1:    return m_load;
      3'd2:    return m_count;
      3'd3:    return {31'b0, m_exp};
      3'd4:    return m_s0;
      3'd5:    return m_s1;
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock, apply the same edge to the model, then check IRQ.
  task automatic step();
    logic        wr_ok, en_eff, set;
    logic [31:0] n_count;
    logic        n_exp;
    @(posedge PCLK);
    if (PRESET) begin
      m_ctrl = '0; m_load = '0; m_count = '0; m_s0 = '0; m_s1 = '0; m_exp = 1'b0;
    end else begin
      wr_ok   = c_commit && c_wr && !c_err;
      en_eff  = m_ctrl[0] && !(wr_ok && c_idx == 3'd0 && !c_wdata[0]);
      set     = 1'b0;
      n_count = m_count;
      n_exp   = m_exp;
      if (en_eff && m_count != 0) begin
        if (m_count == 1) begin
          n_count = m_ctrl[2] ? m_load : 32'h0;
          set = 1'b1;
        end else begin
          n_count = m_count - 1;
        end
      end
      if (wr_ok) begin
        case (c_idx)
          3'd0: m_ctrl = c_wdata[2:0];
          3'd1: begin m_load = c_wdata; n_count = c_wdata; set = 1'b0; end
          3'd3: if (c_wdata[0]) n_exp = 1'b0;
          3'd4: m_s0 = c_wdata;
          3'd5: m_s1 = c_wdata;
          default: ;
        endcase
      end
      if (set) n_exp = 1'b1;
      m_count = n_count;
      m_exp   = n_exp;
    end
    c_commit = 1'b0;
    #1;
    check_eq("irq", IRQ, m_exp & m_ctrl[1]);
  endtask

  task automatic idle(input int n);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (n) step();
  endtask

  task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    logic [2:0] idx;
    logic       err;
    exp_t       e;
    idx = addr[4:2];
    err = (addr[15:5] != 0) || (idx >= 3'd6) || (wr && idx == 3'd2);
    rdata = '0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    #1 check_eq("setup_pready", PREADY, 0);
    step();
    PENABLE = 1'b1;
    for (int k = 0; k <= WAIT; k++) begin
      #1;
      if (k < WAIT) begin
        check_eq("wait_pready", PREADY, 0);
        check_eq("wait_prdata", PRDATA, 0);
      end else begin
        e.data = err ? 32'h0 : model_read(idx);
        e.err  = err;
        sb.push_back(e);
        check_eq("access_pready", PREADY, 1);
        e = sb.pop_front();
        check_eq("pslverr", PSLVERR, e.err);
        check_eq("prdata", PRDATA, e.data);
        rdata = PRDATA;
        c_commit = 1'b1; c_wr = wr; c_err = err; c_idx = idx; c_wdata = wdata;
      end
      step();
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    c_commit = 1'b0; c_wr = 1'b0; c_err = 1'b0; c_idx = '0; c_wdata = '0;
    m_ctrl = '0; m_load = '0; m_count = '0; m_s0 = '0; m_s1 = '0; m_exp = 1'b0;
    step(); step();
    PRESET = 1'b0;
    check_eq("rst_pready", PREADY, 0);
    check_eq("rst_pslverr", PSLVERR, 0);
    check_eq("rst_prdata", PRDATA, 0);
    check_eq("rst_irq", IRQ, 0);

    // Scratch write/read with wait states
    apb_xfer(1'b1, 16'h10, 32'hDEADBEEF, rd);
    apb_xfer(1'b0, 16'h10, 32'h0, rd);
    check_eq("scratch0_rd", rd, 32'hDEADBEEF);

    // One-shot countdown
    apb_xfer(1'b1, 16'h04, 32'd5, rd);
    apb_xfer(1'b1, 16'h00, 32'h3, rd);
    repeat (3) apb_xfer(1'b0, 16'h08, 32'h0, rd);
    idle(4);
    apb_xfer(1'b0, 16'h08, 32'h0, rd);
    check_eq("count_stuck_zero", rd, 0);
    apb_xfer(1'b0, 16'h0C, 32'h0, rd);
    check_eq("oneshot_expired", rd, 1);
    check_eq("oneshot_irq", IRQ, 1);

    // Auto-reload and W1C off the expiry cycle
    apb_xfer(1'b1, 16'h0C, 32'h1, rd);
    apb_xfer(1'b1, 16'h00, 32'h7, rd);
    apb_xfer(1'b1, 16'h04, 32'd3, rd);
    repeat (4) apb_xfer(1'b0, 16'h08, 32'h0, rd);
    for (int n = 0; n < 20 && m_count != 3; n++) idle(1);
    apb_xfer(1'b1, 16'h0C, 32'h1, rd);
    check_eq("w1c_irq_clr", IRQ, 0);

    // Error accesses leave registers alone
    apb_xfer(1'b1, 16'h00, 32'h0, rd);
    apb_xfer(1'b1, 16'h08, 32'h55, rd);
    apb_xfer(1'b1, 16'h1C, 32'h66, rd);
    apb_xfer(1'b0, 16'h20, 32'h0, rd);
    check_eq("oob_prdata", rd, 0);
    apb_xfer(1'b0, 16'h08, 32'h0, rd);
    apb_xfer(1'b0, 16'h04, 32'h0, rd);
    apb_xfer(1'b0, 16'h10, 32'h0, rd);
    check_eq("scratch0_kept", rd, 32'hDEADBEEF);
    apb_xfer(1'b0, 16'h1A, 32'h0, rd);

    // W1C landing exactly on the expiry edge
    apb_xfer(1'b1, 16'h0C, 32'h1, rd);
    apb_xfer(1'b1, 16'h04, 32'd20, rd);
    apb_xfer(1'b1, 16'h00, 32'h3, rd);
    for (int n = 0; n < 40 && m_count != 4; n++) idle(1);
    apb_xfer(1'b1, 16'h0C, 32'h1, rd);
    apb_xfer(1'b0, 16'h0C, 32'h0, rd);
    check_eq("w1c_race_expired", rd, 1);

    // Reset in the middle of a SCRATCH1 write
    apb_xfer(1'b1, 16'h14, 32'h12345678, rd);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h14; PWDATA = 32'hFFFF0000;
    step();
    PENABLE = 1'b1;
    #1 check_eq("rst_mid_wait", PREADY, 0);
    PRESET = 1'b1;
    step();
    check_eq("rst_mid_pready", PREADY, 0);
    check_eq("rst_mid_pslverr", PSLVERR, 0);
    check_eq("rst_mid_prdata", PRDATA, 0);
    check_eq("rst_mid_irq", IRQ, 0);
    PRESET = 1'b0;
    idle(1);
    apb_xfer(1'b0, 16'h14, 32'h0, rd);
    check_eq("scratch1_after_rst", rd, 0);
    apb_xfer(1'b0, 16'h00, 32'h0, rd);
    apb_xfer(1'b0, 16'h10, 32'h0, rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
